if_id_fetch: RTL and testbench

- Fetch stage that sits directly downstream of the program counter.
- Takes the current PC (word address, increments by 1) and issues one request at a time to a variable-latency instruction memory.
- Holds the returned instruction in the IF/ID pipeline register for decode.
- Generates pc_hold so the PC freezes while a fetch is outstanding or decode is stalled, and squashes in-flight or registered instructions on jump.

---
 rtl/if_id_fetch.sv | 146 ++++++++++++++
 tb/tb_if_id_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// if_id_fetch: fetch stage that issues one instruction-memory request at a time and holds the result in IF/ID
//   Optional build macro IMEM_TIMEOUT_EN: bounds the wait for imem_rvalid to TIMEOUT_CYCLES, injects NOP_INSTR
//   and raises the sticky fetch_err flag; without it the stage waits indefinitely and fetch_err is tied 0.
//   Ports:
//     clk, rst            clock and asynchronous active-high reset
//     pc_in               current PC from the PC stage
//     jump                redirect/flush (same cycle the PC loads the jump target)
//     stall               decode cannot accept a new IF/ID entry
//     pc_hold             PC must not advance this cycle
//     imem_req/imem_addr  one-cycle request pulse and its address
//     imem_rdata/rvalid   returned instruction, one response per request
//     if_id_pc/instr/valid  IF/ID pipeline register
//     fetch_err           sticky timeout flag
module if_id_fetch #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] NOP_INSTR      = 32'h00000013,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            jump,
    input  logic            stall,
    output logic            pc_hold,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t          r_state, w_next;
    logic            r_drop, w_drop_next;
    logic            r_req;
    logic [XLEN-1:0] r_req_pc, r_skid_pc, r_skid_instr, r_ifid_pc, r_ifid_instr;
    logic            r_ifid_valid;
    logic            w_timeout, w_load_ifid, w_load_skid, w_hold, w_issue;
    logic [XLEN-1:0] w_fill;

    // A timeout completes the fetch with a NOP in place of the missing response
    assign w_fill  = imem_rvalid ? imem_rdata : NOP_INSTR;
    assign w_issue = (r_state == S_IDLE) && !jump;

`ifdef IMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == S_WAIT) && !imem_rvalid && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + 1'b1 : '0;
            r_err <= r_err | w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_drop_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_drop_next = r_drop;
        w_load_ifid = 1'b0;
        w_load_skid = 1'b0;
        w_hold      = 1'b1;
        if (jump) begin
            // PC loads the jump target now; whatever is in flight belongs to the old path
            w_hold      = 1'b0;
            w_drop_next = (r_state == S_WAIT) && !imem_rvalid;
            w_next      = (w_drop_next && !w_timeout) ? S_WAIT : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_WAIT;
                S_WAIT: if (imem_rvalid || w_timeout) begin
                    w_next      = (!r_drop && stall) ? S_HOLD : S_IDLE;
                    // a timed-out request still owes a late response, so drop stays armed
                    w_drop_next = w_timeout;
                    w_load_skid = !r_drop && stall;
                    w_load_ifid = !r_drop && !stall;
                    w_hold      = r_drop || stall;
                end
                S_HOLD: if (!stall) begin
                    w_next      = S_IDLE;
                    w_load_ifid = 1'b1;
                    w_hold      = 1'b0;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_req_pc     <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_req <= w_issue;
            if (w_issue)
                r_req_pc <= pc_in;
            if (w_load_skid) begin
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= w_fill;
            end
            if (jump) begin
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= NOP_INSTR;
            end else if (w_load_ifid) begin
                r_ifid_pc    <= (r_state == S_HOLD) ? r_skid_pc : r_req_pc;
                r_ifid_instr <= (r_state == S_HOLD) ? r_skid_instr : w_fill;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    assign pc_hold     = w_hold;
    assign imem_req    = r_req;
    assign imem_addr   = r_req_pc;
    assign if_id_pc    = r_ifid_pc;
    assign if_id_instr = r_ifid_instr;
    assign if_id_valid = r_ifid_valid;
endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: table-driven and scoreboarded bench for if_id_fetch
module tb_if_id_fetch;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          lat;
        int          stall_n;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        jump = 1'b0;
    logic        stall = 1'b0;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    vec_t        vecs[7];
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;

    if_id_fetch dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .jump(jump), .stall(stall),
        .pc_hold(pc_hold), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        checks--;
        e = sb.pop_front();
        chk("ifid_pc", if_id_pc, e.pc);
        chk("ifid_instr", if_id_instr, e.instr);
        chk("ifid_valid", if_id_valid, 1);
        chk("idle_hold", pc_hold, 1);
        chk("idle_no_req", imem_req, 0);
        m_pc = e.pc;
        m_instr = e.instr;
        m_valid = 1'b1;
    endtask

    // Entered at the negedge of the request cycle; leaves at a negedge in IDLE.
    task automatic complete(input vec_t v);
        for (int i = 1; i < v.lat; i++) begin
            @(negedge clk);
            chk("wait_hold", pc_hold, 1);
            chk("req_pulse", imem_req, 0);
        end
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = v.data;
        stall = v.stall_n > 0;
        sb.push_back('{v.exp_pc, v.exp_instr});
        #1 chk("rvalid_hold", pc_hold, (v.stall_n > 0) ? 1 : 0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        for (int i = 0; i < v.stall_n; i++) begin
            chk("stall_pc", if_id_pc, m_pc);
            chk("stall_instr", if_id_instr, m_instr);
            chk("stall_valid", if_id_valid, m_valid);
            chk("stall_hold", pc_hold, 1);
            chk("stall_no_req", imem_req, 0);
            @(negedge clk);
        end
        if (v.stall_n > 0) begin
            stall = 1'b0;
            #1 chk("unstall_hold", pc_hold, 0);
            @(negedge clk);
        end
        pop_check();
    endtask

    task automatic do_fetch(input vec_t v);
        pc_in = v.pc;
        @(negedge clk);
        chk("req", imem_req, 1);
        chk("req_addr", imem_addr, v.pc);
        chk("req_hold", pc_hold, 1);
        complete(v);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] data, input int lat, input int sn);
        return '{pc, data, lat, sn, pc, data};
    endfunction

    initial begin
        vecs[0] = mk(32'h0, 32'hA0000000, 1, 0);
        vecs[1] = mk(32'h1, 32'hA0000001, 1, 0);
        vecs[2] = mk(32'h2, 32'hA0000002, 1, 0);
        vecs[3] = mk(32'h5, 32'hDEADBEEF, 4, 0);
        vecs[4] = mk(32'h6, 32'h12345678, 2, 3);
        vecs[5] = mk(32'h7, 32'h0BADF00D, 3, 1);
        vecs[6] = mk(32'hFFFFFFFF, 32'hFEEDFACE, 1, 0);

        @(negedge clk);
        chk("rst_hold", pc_hold, 1);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_pc", if_id_pc, 0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_err", fetch_err, 0);
        rst = 1'b0;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // jump while waiting: response two cycles later must be squashed
        pc_in = 32'h40;
        @(negedge clk);
        chk("j_req", imem_req, 1);
        chk("j_addr", imem_addr, 32'h40);
        jump = 1'b1;
        pc_in = 32'h80;
        #1 chk("j_hold", pc_hold, 0);
        @(negedge clk);
        jump = 1'b0;
        m_valid = 1'b0;
        m_instr = NOP;
        chk("j_valid", if_id_valid, 0);
        chk("j_instr", if_id_instr, NOP);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h11111111;
        #1 chk("j_drop_hold", pc_hold, 1);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("j_drop_valid", if_id_valid, 0);
        chk("j_drop_instr", if_id_instr, NOP);
        chk("j_drop_req", imem_req, 0);
        @(negedge clk);
        chk("j_new_req", imem_req, 1);
        chk("j_new_addr", imem_addr, 32'h80);
        complete(mk(32'h80, 32'hCAFE0080, 2, 0));

        // jump while holding a stalled response: skid content discarded
        pc_in = 32'h50;
        @(negedge clk);
        chk("h_req", imem_req, 1);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h55555555;
        stall = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        jump = 1'b1;
        pc_in = 32'h60;
        #1 chk("h_jump_hold", pc_hold, 0);
        @(negedge clk);
        jump = 1'b0;
        m_valid = 1'b0;
        m_instr = NOP;
        chk("h_valid", if_id_valid, 0);
        chk("h_instr", if_id_instr, NOP);
        stall = 1'b0;
        #1 chk("h_idle_hold", pc_hold, 1);
        @(negedge clk);
        chk("h_new_req", imem_req, 1);
        chk("h_new_addr", imem_addr, 32'h60);
        chk("h_skid_gone", if_id_valid, 0);
        complete(mk(32'h60, 32'h60606060, 1, 0));

        // asynchronous reset mid-wait, then a stale response in IDLE
        pc_in = 32'h99;
        @(negedge clk);
        chk("r_req", imem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_req0", imem_req, 0);
        chk("r_addr0", imem_addr, 0);
        chk("r_hold", pc_hold, 1);
        chk("r_valid", if_id_valid, 0);
        chk("r_instr", if_id_instr, NOP);
        chk("r_pc", if_id_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = '0;
        m_instr = NOP;
        m_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h22222222;
        pc_in = 32'h9A;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("r_stale_valid", if_id_valid, 0);
        chk("r_new_req", imem_req, 1);
        chk("r_new_addr", imem_addr, 32'h9A);
        complete(mk(32'h9A, 32'h9A9A9A9A, 1, 0));

        // memory slow to respond
        pc_in = 32'h70;
        @(negedge clk);
        chk("t_req", imem_req, 1);
`ifdef IMEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("t_err_pre", fetch_err, 0);
        chk("t_adv", pc_hold, 0);
        pc_in = 32'h71;
        @(negedge clk);
        chk("t_err", fetch_err, 1);
        chk("t_valid", if_id_valid, 1);
        chk("t_instr", if_id_instr, NOP);
        chk("t_pc", if_id_pc, 32'h70);
        m_pc = 32'h70;
        m_instr = NOP;
        m_valid = 1'b1;
        @(negedge clk);
        chk("t_req2", imem_req, 1);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h33333333;
        #1 chk("t_late_hold", pc_hold, 1);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("t_late_instr", if_id_instr, NOP);
        chk("t_err_sticky", fetch_err, 1);
        @(negedge clk);
        chk("t_req3", imem_req, 1);
        chk("t_addr3", imem_addr, 32'h71);
        complete(mk(32'h71, 32'h71717171, 1, 0));
`else
        for (int i = 0; i < 19; i++) @(negedge clk);
        chk("t_noerr", fetch_err, 0);
        chk("t_wait_hold", pc_hold, 1);
        chk("t_wait_valid", if_id_valid, m_valid);
        chk("t_wait_instr", if_id_instr, m_instr);
        chk("t_wait_req", imem_req, 0);
        complete(mk(32'h70, 32'h70707070, 1, 0));
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
